// File: rtl/crom_loader_if.sv
// Wishbone connection between the CROM loader (master) and the cartridge ROM slave port.
// Address bit 21 selects the ROM array; bits 1:0 select a control register otherwise.
interface crom_loader_if;
  logic [21:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_we_o;
  logic [0:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/crom_loader.sv
// Session loader: probes CROM capacity, streams an image into the ROM array,
// then writes the control byte and reads it back for verification.
module crom_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [21:0]   length,
  input  logic [7:0]    cfg,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  crom_loader_if.master wb
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [21:0] ADR_CTRL  = 22'h000000;
  localparam logic [21:0] ADR_PROBE = 22'h000002;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_SIZE = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_CMP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_FETCH,
    S_WRITE,
    S_CFG_WR,
    S_CFG_RD,
    S_END
  } state_t;

  state_t        state_reg, state_next;
  logic          gap_reg, gap_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [21:0]   length_reg, length_next;
  logic [7:0]    cfg_reg, cfg_next;
  logic [20:0]   offset_reg, offset_next;
  logic [7:0]    byte_reg, byte_next;
  logic [1:0]    err_reg, err_next;

  logic          bus_state;
  logic          stb_on;
  logic          acked;
  logic          tmo_hit;
  logic [21:0]   capacity;
  logic [7:0]    cfg_wr;

  assign bus_state = (state_reg == S_PROBE) || (state_reg == S_WRITE) ||
                     (state_reg == S_CFG_WR) || (state_reg == S_CFG_RD);
  // gap_reg forces one idle strobe cycle between back-to-back bus accesses
  assign stb_on   = bus_state && !gap_reg;
  assign acked    = stb_on && wb.wb_ack_i;
  assign tmo_hit  = stb_on && !wb.wb_ack_i && (tmo_reg == TW'(TIMEOUT - 1));
  assign capacity = (22'(wb.wb_dat_i) + 22'd1) << 13;
  assign cfg_wr   = cfg_reg & 8'hFE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      gap_reg    <= 1'b0;
      tmo_reg    <= '0;
      length_reg <= '0;
      cfg_reg    <= '0;
      offset_reg <= '0;
      byte_reg   <= '0;
      err_reg    <= ERR_OK;
    end else begin
      state_reg  <= state_next;
      gap_reg    <= gap_next;
      tmo_reg    <= tmo_next;
      length_reg <= length_next;
      cfg_reg    <= cfg_next;
      offset_reg <= offset_next;
      byte_reg   <= byte_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    gap_next    = 1'b0;
    tmo_next    = tmo_reg;
    length_next = length_reg;
    cfg_next    = cfg_reg;
    offset_next = offset_reg;
    byte_next   = byte_reg;
    err_next    = err_reg;

    if (stb_on) begin
      tmo_next = wb.wb_ack_i ? '0 : tmo_reg + 1'b1;
    end

    if (tmo_hit) begin
      err_next   = ERR_TMO;
      state_next = S_END;
    end else begin
      case (state_reg)
        S_IDLE: begin
          tmo_next = '0;
          if (start) begin
            length_next = length;
            cfg_next    = cfg;
            err_next    = ERR_OK;
            state_next  = S_PROBE;
          end
        end
        S_PROBE: begin
          if (acked) begin
            if (length_reg > capacity) begin
              err_next   = ERR_SIZE;
              state_next = S_END;
            end else if (length_reg == 22'd0) begin
              gap_next   = 1'b1;
              state_next = S_CFG_WR;
            end else begin
              offset_next = '0;
              state_next  = S_FETCH;
            end
          end
        end
        S_FETCH: begin
          tmo_next = '0;
          if (s_valid) begin
            byte_next  = s_data;
            state_next = S_WRITE;
          end
        end
        S_WRITE: begin
          if (acked) begin
            offset_next = offset_reg + 1'b1;
            if ((22'(offset_reg) + 22'd1) == length_reg) begin
              gap_next   = 1'b1;
              state_next = S_CFG_WR;
            end else begin
              state_next = S_FETCH;
            end
          end
        end
        S_CFG_WR: begin
          if (acked) begin
            gap_next   = 1'b1;
            state_next = S_CFG_RD;
          end
        end
        S_CFG_RD: begin
          if (acked) begin
            err_next   = (wb.wb_dat_i == cfg_wr) ? ERR_OK : ERR_CMP;
            state_next = S_END;
          end
        end
        S_END: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    s_ready     = (state_reg == S_FETCH);
    busy        = (state_reg != S_IDLE) && (state_reg != S_END);
    done        = (state_reg == S_END);
    err         = err_reg;
    wb.wb_cyc_o = busy;
    wb.wb_stb_o = stb_on;
    wb.wb_sel_o = stb_on;
    wb.wb_we_o  = 1'b0;
    wb.wb_adr_o = '0;
    wb.wb_dat_o = '0;
    case (state_reg)
      S_PROBE: begin
        wb.wb_adr_o = ADR_PROBE;
      end
      S_WRITE: begin
        wb.wb_we_o  = 1'b1;
        wb.wb_adr_o = {1'b1, offset_reg};
        wb.wb_dat_o = byte_reg;
      end
      S_CFG_WR: begin
        wb.wb_we_o  = 1'b1;
        wb.wb_adr_o = ADR_CTRL;
        wb.wb_dat_o = cfg_wr;
      end
      S_CFG_RD: begin
        wb.wb_adr_o = ADR_CTRL;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/crom_loader.md
Name: crom_loader

Overview:
- Wishbone master that fills the cartridge ROM array from a byte stream and then programs its control register.
- Sits between the host/boot path (SD or UART byte source) and the CROM wishbone slave port.
- Per session: probe CROM capacity, reject oversize images, write N bytes to ascending array addresses, write the control byte, then read it back to verify.

Parameters:
- TIMEOUT, 1024, cycles to wait for wb_ack_i on any single access before aborting; must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  one-cycle request to begin a session; sampled only in IDLE
- length  in  [0:21]  image byte count, latched at start
- cfg  in  [0:7]  control byte to program, latched at start; layout {mask_width[0:3], invbank, mbx, mm, 0}
- s_data  in  [0:7]  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts byte
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end, success or failure
- err  out  [0:1]  00 ok, 01 image too large, 10 ack timeout, 11 readback mismatch; valid from done until next start
- wb_adr_o  out  [0:21]  wishbone address; bit 0 = 1 selects array, bit 0 = 0 selects control, [20:21] = register
- wb_dat_o  out  [0:7]  write data
- wb_dat_i  in  [0:7]  read data
- wb_we_o  out  1  write enable
- wb_sel_o  out  [0:0]  byte select
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  acknowledge

Behaviour:
- Reset values: all outputs 0 (s_ready, busy, done, err, wb_*). State goes to IDLE. Reset mid-session drops cyc/stb on the next edge with no further access.
- IDLE:
  - start=1 latches length and cfg, clears err, sets busy=1, goes to PROBE.
  - start while busy is ignored.
- Bus rules:
  - wb_cyc_o is high from PROBE entry to session end.
  - wb_stb_o is held with stable adr/dat/we until wb_ack_i is sampled high.
  - The cycle after an ack, stb=0 for at least one cycle.
  - wb_sel_o = 1 whenever stb = 1.
  - A withheld ack (slave collision) is tolerated. The counter resets on each new strobe; after TIMEOUT strobe cycles with no ack, go to END with err=10.
- PROBE:
  - Read adr 0x000002. On ack, capture wb_dat_i as B.
  - Capacity = (B+1)*8192, computed at 22 bits.
  - length > capacity: go to END, err=01, no array writes.
  - length = 0: go to CFG_WR.
  - Otherwise: go to FETCH with offset = 0.
- FETCH:
  - s_ready = 1. On s_valid && s_ready, capture s_data and go to WRITE.
  - A stream stall has no timeout.
- WRITE:
  - we=1, adr = {1'b1, offset[1:21]}, dat = byte.
  - On ack: offset+1. If offset+1 == length go to CFG_WR, else go to FETCH.
  - s_ready = 0 in all states except FETCH; exactly length bytes are consumed.
- CFG_WR:
  - we=1, adr 0x000000, dat = cfg with bit 7 forced to 0.
  - On ack go to CFG_RD.
- CFG_RD:
  - Read adr 0x000000. On ack compare wb_dat_i with the written value.
  - Mismatch: err=11. Match: err=00. Go to END.
- END:
  - Deassert cyc/stb, pulse done=1 for one cycle, busy=0, return to IDLE.
- Throughput: at most one byte per 3 cycles with a 1-cycle-ack slave.

Test Plan:
- Slave model with BANKS=64, ack 1 cycle after stb; start, length=4, cfg=0x62, stream A5,5A,00,FF. Required:
  - array writes to 0x200000..0x200003 with those bytes;
  - control write 0x62, then readback;
  - done with err=00, s_ready high for exactly 4 handshakes.
- BANKS=3 model (probe returns 0x02); length=0x006001 -> err=01, no array write strobes, done one cycle after probe ack, s_ready never high.
- length=0, cfg=0x25 -> probe, control write 0x24, readback 0x24, err=00.
- Slave withholds ack for 5 cycles on the byte 2 write. Required: stb/adr/dat stable across stall, no duplicate or skipped write, err=00.
- Slave never acks the first array write, TIMEOUT=16 -> err=10 and done exactly 16 strobe cycles after stb rises; cyc low after.
- Model returns 0x00 on control readback with cfg=0x62 -> err=11. Reset asserted mid-WRITE -> cyc/stb/busy all 0 next edge; a new start then runs cleanly.
